uart_tx: RTL and testbench

Byte-serialising UART transmitter that drives the line consumed by `uart_rx`, sitting directly upstream of it in the UART example. Bytes arrive on a request/ready handshake into a small FIFO. They leave as 8N1 frames: start bit, 8 data bits LSB first, one stop bit. Each bit is held `cycles_per_bit` clocks, so it matches `uart_rx` configured with the same parameter. A running checksum of transmitted bytes mirrors the receiver's `sum` for end-to-end loopback checking.

---
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx.sv | 116 +++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_if : byte enqueue handshake into the UART transmitter
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface uart_tx_if;
    logic       tick_i_req;
    logic [7:0] tick_i_data;
    logic       ready_ret;

    modport master (
        output tick_i_req,
        output tick_i_data,
        input  ready_ret
    );

    modport slave (
        input  tick_i_req,
        input  tick_i_data,
        output ready_ret
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx  : FIFO-buffered 8N1 serialiser with running byte checksum
// Revision : 1.0
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CYCLES_PER_BIT = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  wire logic                            clock,
    input  wire logic                            tick_i_reset,
    uart_tx_if.slave                             bus,
    output logic                                 serial_ret,
    output logic                                 idle_ret,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count_ret,
    output logic [31:0]                          sent_ret
);

    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_YW = $clog2(CYCLES_PER_BIT);
    localparam logic [c_YW-1:0] c_CYC_MAX = c_YW'(CYCLES_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(FIFO_DEPTH);

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [c_PW-1:0] wptr_q,   wptr_d;
    logic [c_PW-1:0] rptr_q,   rptr_d;
    logic [c_CW-1:0] count_q,  count_d;
    logic [9:0]      shift_q,  shift_d;
    logic [3:0]      cursor_q, cursor_d;
    logic [c_YW-1:0] cycle_q,  cycle_d;
    logic [31:0]     sent_q,   sent_d;

    logic       w_ready;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_byte;

    assign w_ready = (count_q < c_DEPTH);
    assign w_push  = bus.tick_i_req && w_ready;
    // Reloading during the final stop-bit cycle keeps back-to-back frames gapless.
    assign w_pop   = (count_q != '0) &&
                     ((cursor_q == 4'd0) || ((cursor_q == 4'd1) && (cycle_q == '0)));
    assign w_byte  = mem_q[rptr_q];

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        shift_d  = shift_q;
        cursor_d = cursor_q;
        cycle_d  = cycle_q;
        sent_d   = sent_q;

        if (w_push) begin
            wptr_d = wptr_q + 1'b1;
        end

        if (w_pop) begin
            shift_d  = {1'b1, w_byte, 1'b0};
            cursor_d = 4'd10;
            cycle_d  = c_CYC_MAX;
            sent_d   = sent_q + {24'd0, w_byte};
            rptr_d   = rptr_q + 1'b1;
        end else if (cursor_q != 4'd0) begin
            if (cycle_q != '0) begin
                cycle_d = cycle_q - 1'b1;
            end else begin
                shift_d  = {1'b1, shift_q[9:1]};
                cursor_d = cursor_q - 4'd1;
                cycle_d  = c_CYC_MAX;
            end
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (tick_i_reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            shift_q  <= '1;
            cursor_q <= 4'd0;
            cycle_q  <= '0;
            sent_q   <= 32'd0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            cursor_q <= cursor_d;
            cycle_q  <= cycle_d;
            sent_q   <= sent_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (!tick_i_reset && w_push) begin
            mem_q[wptr_q] <= bus.tick_i_data;
        end
    end

    assign serial_ret    = (cursor_q != 4'd0) ? shift_q[0] : 1'b1;
    assign bus.ready_ret = w_ready;
    assign idle_ret      = (count_q == '0) && (cursor_q == 4'd0);
    assign count_ret     = count_q;
    assign sent_ret      = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx : self-checking bench for uart_tx (frame monitor + scoreboard)
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        serial;
    logic        idle;
    logic [2:0]  count;
    logic [31:0] sent;

    uart_tx_if bus ();

    uart_tx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock        (clk),
        .tick_i_reset (rst),
        .bus          (bus.slave),
        .serial_ret   (serial),
        .idle_ret     (idle),
        .count_ret    (count),
        .sent_ret     (sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int frames_seen = 0;
    logic [7:0] sb [$];
    int starts [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame monitor: 40 samples per frame, one per clock, taken at negedge.
    logic [39:0] mon_s;
    int          mon_n = 0;

    task automatic frame_eval();
        logic [9:0] bits;
        logic       shape_ok;
        logic [7:0] exp;
        shape_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bits[k] = mon_s[k*CPB];
            for (int j = 1; j < CPB; j++)
                if (mon_s[k*CPB+j] !== bits[k]) shape_ok = 1'b0;
        end
        frames_seen++;
        check("frame_shape", {31'd0, shape_ok}, 32'd1);
        check("frame_stop", {31'd0, bits[9]}, 32'd1);
        if (sb.size() == 0) begin
            check("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
        end else begin
            exp = sb.pop_front();
            check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_n = 0;
        end else if (mon_n == 0) begin
            if (serial === 1'b0) begin
                mon_s[0] = 1'b0;
                mon_n = 1;
                starts.push_back(cyc);
            end
        end else begin
            mon_s[mon_n] = serial;
            mon_n++;
            if (mon_n == 10*CPB) begin
                frame_eval();
                mon_n = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (idle === 1'b1) break;
        end
        if (i == budget) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic push(input logic [7:0] b);
        bus.tick_i_req  = 1'b1;
        bus.tick_i_data = b;
        tick();
        bus.tick_i_req  = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [31:0] exp_sent;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [9:0] frame;
        int base;
        int fcount;

        // Cumulative checksum continues on from the 0x55 sequence.
        vecs[0] = '{8'h00, 32'h0000_0055};
        vecs[1] = '{8'hA5, 32'h0000_00FA};
        vecs[2] = '{8'h3C, 32'h0000_0136};
        vecs[3] = '{8'hFF, 32'h0000_0235};

        rst = 1'b1;
        bus.tick_i_req  = 1'b0;
        bus.tick_i_data = 8'h00;
        do_reset();

        check("rst_serial", {31'd0, serial}, 32'd1);
        check("rst_ready",  {31'd0, bus.ready_ret}, 32'd1);
        check("rst_idle",   {31'd0, idle}, 32'd1);
        check("rst_count",  {29'd0, count}, 32'd0);
        check("rst_sent",   sent, 32'd0);

        // Exact single-frame timing for 0x55.
        frame = {1'b1, 8'h55, 1'b0};
        sb.push_back(8'h55);
        push(8'h55);
        check("e0_count",  {29'd0, count}, 32'd1);
        check("e0_serial", {31'd0, serial}, 32'd1);
        for (int k = 0; k < 10*CPB; k++) begin
            tick();
            check($sformatf("bit_cycle_%0d", k), {31'd0, serial}, {31'd0, frame[k/CPB]});
            if (k == 0) check("sent_at_load", sent, 32'h55);
        end
        tick();
        check("single_idle", {31'd0, idle}, 32'd1);
        check("single_sent", sent, 32'h55);

        for (int v = 0; v < 4; v++) begin
            sb.push_back(vecs[v].data);
            push(vecs[v].data);
            wait_idle("vec", 60);
            check($sformatf("vec%0d_sent", v), sent, vecs[v].exp_sent);
        end
        check("vec_sb_empty", sb.size(), 32'd0);

        // Back-to-back: three gapless frames.
        do_reset();
        base = starts.size();
        sb.push_back(8'h01); sb.push_back(8'h80); sb.push_back(8'hFF);
        push(8'h01); push(8'h80); push(8'hFF);
        wait_idle("b2b", 200);
        check("b2b_sent", sent, 32'h180);
        check("b2b_frames", starts.size() - base, 32'd3);
        if (starts.size() - base == 3) begin
            check("b2b_gap1", starts[base+1] - starts[base],   10*CPB);
            check("b2b_gap2", starts[base+2] - starts[base+1], 10*CPB);
        end
        check("b2b_sb_empty", sb.size(), 32'd0);

        // Overflow: sixth byte is dropped.
        do_reset();
        fcount = frames_seen;
        for (int i = 0; i < 5; i++) sb.push_back(8'h10 + 8'(i));
        bus.tick_i_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.tick_i_data = 8'h10 + 8'(i);
            tick();
            if (i == 4) begin
                check("ovf_count_full", {29'd0, count}, 32'd4);
                check("ovf_ready_low",  {31'd0, bus.ready_ret}, 32'd0);
            end
        end
        bus.tick_i_req = 1'b0;
        check("ovf_count_after_drop", {29'd0, count}, 32'd4);
        wait_idle("ovf", 300);
        check("ovf_frames", frames_seen - fcount, 32'd5);
        check("ovf_sent", sent, 32'h5A);
        check("ovf_sb_empty", sb.size(), 32'd0);

        // Reset during data bit 3 of 0xA5 with two bytes queued.
        do_reset();
        fcount = frames_seen;
        push(8'hA5); push(8'h11); push(8'h22);
        check("mid_count", {29'd0, count}, 32'd2);
        for (int i = 0; i < 16; i++) tick();
        check("mid_bit3_low", {31'd0, serial}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_serial", {31'd0, serial}, 32'd1);
        check("mid_rst_count",  {29'd0, count}, 32'd0);
        check("mid_rst_sent",   sent, 32'd0);
        check("mid_rst_idle",   {31'd0, idle}, 32'd1);
        for (int i = 0; i < 100; i++) tick();
        check("mid_no_frames", frames_seen - fcount, 32'd0);
        check("mid_line_high", {31'd0, serial}, 32'd1);

        // Checksum wraps modulo 2^32.
        do_reset();
        force dut.sent_q = 32'hFFFF_FF80;
        tick();
        release dut.sent_q;
        tick();
        check("wrap_preload", sent, 32'hFFFF_FF80);
        sb.push_back(8'hFF);
        push(8'hFF);
        wait_idle("wrap1", 60);
        check("wrap_sent1", sent, 32'h0000_007F);
        sb.push_back(8'h01);
        push(8'h01);
        wait_idle("wrap2", 60);
        check("wrap_sent2", sent, 32'h0000_0080);
        check("wrap_sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
